// File: rtl/dram_ctrl_pkg.sv
// Shared types and default timing for the single-bank DRAM access controller.
package dram_ctrl_pkg;

  // Controller states: idle, precharge, activate, column access, refresh.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ACT  = 3'd2,
    ST_RW   = 3'd3,
    ST_REF  = 3'd4
  } state_e;

  // Default geometry and timing, in clock cycles.
  localparam int unsigned DEF_ROW_W        = 5;
  localparam int unsigned DEF_COL_W        = 5;
  localparam int unsigned DEF_T_RP         = 2;
  localparam int unsigned DEF_T_RCD        = 2;
  localparam int unsigned DEF_T_CL         = 2;
  localparam int unsigned DEF_T_RFC        = 4;
  localparam int unsigned DEF_REF_INTERVAL = 64;

  // Largest of four timing values, used to size the state-length counter.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter. Raises ref_pending when the counter
// reaches zero and drops it when the controller enters its refresh state.
module dram_refresh_timer
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ref_clear_i,
  output logic ref_pending_o
);

  localparam int unsigned CW = $clog2(REF_INTERVAL) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(REF_INTERVAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;

  // Next-state: reload at zero and set pending; a fresh expiry outranks a
  // simultaneous clear, and an expiry while already pending just stays pending.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (cnt_q == '0) begin
      cnt_d  = RELOAD;
      pend_d = 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (ref_clear_i) pend_d = 1'b0;
    end
  end

  // Interval counter and pending flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= RELOAD;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign ref_pending_o = pend_q;

endmodule

// File: rtl/dram_access_ctrl.sv
// Single-bank DRAM access sequencer with an open-page policy and periodic
// refresh. Every strobe and address leaving the block is registered.
//
// Request handshake: a request transfers on a rising edge where req_valid_i
// and req_ready_o are both high; req_ready_o is high only in IDLE with no
// refresh pending and does not depend on req_valid_i. The request fields are
// captured on that edge and inputs are ignored until the FSM returns to IDLE.
// There is no response back-pressure: rsp_valid_o is a one-cycle pulse.
module dram_access_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned ROW_W        = DEF_ROW_W,
  parameter int unsigned COL_W        = DEF_COL_W,
  parameter int unsigned T_RP         = DEF_T_RP,
  parameter int unsigned T_RCD        = DEF_T_RCD,
  parameter int unsigned T_CL         = DEF_T_CL,
  parameter int unsigned T_RFC        = DEF_T_RFC,
  parameter int unsigned REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [ROW_W-1:0] req_row_i,
  input  logic [COL_W-1:0] req_col_i,
  output logic             ras_o,
  output logic [ROW_W-1:0] row_addr_o,
  output logic             cas_o,
  output logic [COL_W-1:0] col_addr_o,
  output logic             we_o,
  output logic             pre_o,
  output logic             ref_o,
  output logic             rsp_valid_o,
  // Debug visibility of the FSM and open-page tracking.
  output state_e           state_o,
  output logic             row_open_o,
  output logic [ROW_W-1:0] open_row_o,
  output logic             ref_pending_o
);

  localparam int unsigned TW = $clog2(max4(T_RP, T_RCD, T_CL, T_RFC)) + 1;

  state_e           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             row_open_q, row_open_d;
  logic [ROW_W-1:0] open_row_q, open_row_d;
  logic             pre_for_ref_q, pre_for_ref_d;
  logic             cap_we_q, cap_we_d;
  logic [ROW_W-1:0] cap_row_q, cap_row_d;
  logic [COL_W-1:0] cap_col_q, cap_col_d;
  logic             ras_q, ras_d;
  logic [ROW_W-1:0] row_addr_q, row_addr_d;
  logic             cas_q, cas_d;
  logic [COL_W-1:0] col_addr_q, col_addr_d;
  logic             we_q, we_d;
  logic             pre_q, pre_d;
  logic             ref_q, ref_d;
  logic             rsp_q, rsp_d;

  logic ref_pending;
  logic ref_entry;
  logic accept;
  logic row_hit;
  logic last_cycle;

  dram_refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_refresh_timer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .ref_clear_i  (ref_entry),
    .ref_pending_o(ref_pending)
  );

  assign req_ready_o = (state_q == ST_IDLE) && !ref_pending;
  assign accept      = req_valid_i && req_ready_o;
  assign row_hit     = row_open_q && (open_row_q == req_row_i);
  assign last_cycle  = (cnt_q == TW'(1));

  // Next-state, state-length counter and output strobe generation. Strobes
  // fire on the cycle a state is entered; the counter is loaded with the
  // state length on entry and the state is left when it reaches one.
  always_comb begin
    state_d       = state_q;
    cnt_d         = (cnt_q > TW'(1)) ? cnt_q - 1'b1 : '0;
    row_open_d    = row_open_q;
    open_row_d    = open_row_q;
    pre_for_ref_d = pre_for_ref_q;
    cap_we_d      = cap_we_q;
    cap_row_d     = cap_row_q;
    cap_col_d     = cap_col_q;
    ras_d         = 1'b0;
    row_addr_d    = '0;
    cas_d         = 1'b0;
    col_addr_d    = '0;
    we_d          = 1'b0;
    pre_d         = 1'b0;
    ref_d         = 1'b0;
    rsp_d         = 1'b0;
    ref_entry     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ref_pending) begin
          // An open row must be closed before the refresh may start.
          if (row_open_q) begin
            state_d       = ST_PRE;
            pre_for_ref_d = 1'b1;
          end else begin
            state_d = ST_REF;
          end
        end else if (accept) begin
          cap_we_d  = req_we_i;
          cap_row_d = req_row_i;
          cap_col_d = req_col_i;
          if (row_hit) begin
            state_d = ST_RW;
          end else if (row_open_q) begin
            state_d       = ST_PRE;
            pre_for_ref_d = 1'b0;
          end else begin
            state_d = ST_ACT;
          end
        end
      end
      ST_PRE: begin
        if (last_cycle) begin
          row_open_d = 1'b0;
          state_d    = pre_for_ref_q ? ST_REF : ST_ACT;
        end
      end
      ST_ACT: begin
        if (last_cycle) begin
          row_open_d = 1'b1;
          open_row_d = cap_row_q;
          state_d    = ST_RW;
        end
      end
      ST_RW: begin
        if (last_cycle) state_d = ST_IDLE;
      end
      ST_REF: begin
        if (last_cycle) begin
          row_open_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entry actions: every transition lands in a different state, so a state
    // change marks the first cycle of the new state.
    if (state_d != state_q) begin
      case (state_d)
        ST_PRE: begin
          pre_d = 1'b1;
          cnt_d = TW'(T_RP);
        end
        ST_ACT: begin
          ras_d      = 1'b1;
          row_addr_d = cap_row_d;
          cnt_d      = TW'(T_RCD);
        end
        ST_RW: begin
          cas_d      = 1'b1;
          col_addr_d = cap_col_d;
          we_d       = cap_we_d;
          cnt_d      = TW'(T_CL);
        end
        ST_REF: begin
          ref_d     = 1'b1;
          ref_entry = 1'b1;
          cnt_d     = TW'(T_RFC);
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end

    // Completion pulse lands on the final access cycle.
    rsp_d = (state_d == ST_RW) && (cnt_d == TW'(1));
  end

  // State, bookkeeping and registered output strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      row_open_q    <= 1'b0;
      open_row_q    <= '0;
      pre_for_ref_q <= 1'b0;
      cap_we_q      <= 1'b0;
      cap_row_q     <= '0;
      cap_col_q     <= '0;
      ras_q         <= 1'b0;
      row_addr_q    <= '0;
      cas_q         <= 1'b0;
      col_addr_q    <= '0;
      we_q          <= 1'b0;
      pre_q         <= 1'b0;
      ref_q         <= 1'b0;
      rsp_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_open_q    <= row_open_d;
      open_row_q    <= open_row_d;
      pre_for_ref_q <= pre_for_ref_d;
      cap_we_q      <= cap_we_d;
      cap_row_q     <= cap_row_d;
      cap_col_q     <= cap_col_d;
      ras_q         <= ras_d;
      row_addr_q    <= row_addr_d;
      cas_q         <= cas_d;
      col_addr_q    <= col_addr_d;
      we_q          <= we_d;
      pre_q         <= pre_d;
      ref_q         <= ref_d;
      rsp_q         <= rsp_d;
    end
  end

  assign ras_o         = ras_q;
  assign row_addr_o    = row_addr_q;
  assign cas_o         = cas_q;
  assign col_addr_o    = col_addr_q;
  assign we_o          = we_q;
  assign pre_o         = pre_q;
  assign ref_o         = ref_q;
  assign rsp_valid_o   = rsp_q;
  assign state_o       = state_q;
  assign row_open_o    = row_open_q;
  assign open_row_o    = open_row_q;
  assign ref_pending_o = ref_pending;

endmodule
